// File: rtl/dr_sync_bridge.sv
// Synchronous bridge around a dual-rail (NULL-convention) combinational block.
// Operands are encoded onto x_1/x_0 rails, completion and NULL are detected on synchronized
// result rails with a settle filter and a timeout, and the decoded result is returned on valid/ready.
module dr_sync_bridge #(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 1,
    parameter int SETTLE    = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  in_data,
    output logic [WIDTH_IN-1:0]  dr_out_1,
    output logic [WIDTH_IN-1:0]  dr_out_0,
    input  logic [WIDTH_OUT-1:0] dr_in_1,
    input  logic [WIDTH_OUT-1:0] dr_in_0,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH_OUT-1:0] res_data,
    output logic                 res_err
);

    typedef enum logic [1:0] {IDLE, DATA_WAIT, NULL_WAIT, RESP} state_t;

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                state_q;
    logic [WIDTH_IN-1:0]   dr_out_1_q, dr_out_0_q;
    logic [WIDTH_OUT-1:0]  meta1_q, meta0_q, s1_q, s0_q;
    logic [WIDTH_OUT-1:0]  res_data_q;
    logic                  res_valid_q, res_err_q, err_q;
    logic [SW-1:0]         settle_q, settle_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic                  comp, nul, ill, watch, settle_done, timeout;

    // Two-flop synchronizer per returning rail; the block output is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta1_q <= '0;
            meta0_q <= '0;
            s1_q    <= '0;
            s0_q    <= '0;
        end else begin
            meta1_q <= dr_in_1;
            meta0_q <= dr_in_0;
            s1_q    <= meta1_q;
            s0_q    <= meta0_q;
        end
    end

    // Rail decode plus settle/timeout next-state; the settle filter watches data or NULL by phase.
    always_comb begin
        comp        = &(s1_q ^ s0_q);
        nul         = ~|(s1_q | s0_q);
        ill         = |(s1_q & s0_q);
        watch       = (state_q == DATA_WAIT) ? comp : nul;
        settle_done = watch && (settle_q == SW'(SETTLE - 1));
        timeout     = (tmo_q == TW'(TIMEOUT - 1));
        settle_d    = watch ? settle_q + SW'(1) : '0;
        tmo_d       = tmo_q + TW'(1);
    end

    // Main handshake FSM; dr_out only moves on IDLE->DATA_WAIT and DATA_WAIT->NULL_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dr_out_1_q  <= '0;
            dr_out_0_q  <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            err_q       <= 1'b0;
            settle_q    <= '0;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dr_out_1_q <= in_data;
                        dr_out_0_q <= ~in_data;
                        settle_q   <= '0;
                        tmo_q      <= '0;
                        err_q      <= 1'b0;
                        state_q    <= DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    settle_q <= settle_d;
                    tmo_q    <= tmo_d;
                    if (ill) begin
                        err_q <= 1'b1;
                    end
                    if (settle_done || timeout) begin
                        // A timed-out capture still returns whatever true rails are present.
                        res_data_q <= s1_q;
                        dr_out_1_q <= '0;
                        dr_out_0_q <= '0;
                        settle_q   <= '0;
                        tmo_q      <= '0;
                        state_q    <= NULL_WAIT;
                        if (!settle_done) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                NULL_WAIT: begin
                    settle_q <= settle_d;
                    tmo_q    <= tmo_d;
                    if (settle_done || timeout) begin
                        res_valid_q <= 1'b1;
                        res_err_q   <= err_q | ~settle_done;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign dr_out_1  = dr_out_1_q;
    assign dr_out_0  = dr_out_0_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: doc/dr_sync_bridge.md
Name: dr_sync_bridge

Overview:
- Synchronous front/back end for a dual-rail (NULL-convention) combinational block.
- Accepts single-rail operands on a valid/ready interface and encodes them as dual-rail codewords (x_1/x_0) on the block inputs.
- Detects completion of the block's dual-rail result, captures it, and returns the block to spacer (all rails 0).
- Delivers the decoded single-rail result on a valid/ready interface.

Parameters:
- WIDTH_IN, 4, number of dual-rail operand bits driven.
- WIDTH_OUT, 1, number of dual-rail result bits monitored.
- SETTLE, 2, consecutive synchronized cycles a codeword or spacer must be observed before it is accepted (min 1).
- TIMEOUT, 15, max cycles in DATA_WAIT or NULL_WAIT before the error path is taken (must be > SETTLE+2).

Ports:
- clk input 1 system clock, rising edge.
- rst_n input 1 asynchronous active-low reset.
- in_valid input 1 operand valid.
- in_ready output 1 bridge can accept an operand.
- in_data input WIDTH_IN single-rail operand.
- dr_out_1 output WIDTH_IN true rails to the dual-rail block.
- dr_out_0 output WIDTH_IN false rails to the dual-rail block.
- dr_in_1 input WIDTH_OUT true rails from the dual-rail block (asynchronous).
- dr_in_0 input WIDTH_OUT false rails from the dual-rail block (asynchronous).
- res_valid output 1 result valid.
- res_ready input 1 result consumer ready.
- res_data output WIDTH_OUT decoded result.
- res_err output 1 error flag, qualified by res_valid.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - dr_out_1/dr_out_0 = 0 (spacer).
  - res_valid, res_data and res_err = 0.
  - Synchronizers, settle counter and timeout counter cleared.
  - in_ready=0 while rst_n is low.
- dr_in rails pass through a 2-flop synchronizer per rail. All decode uses the synchronized copy (s1/s0).
- Completion: every bit has exactly one of s1/s0 high. Null: all s1 and s0 low. Illegal: any bit has s1&s0.
- in_ready = (state==IDLE), combinational.
- IDLE:
  - Spacer driven.
  - On in_valid&in_ready: dr_out_1<=in_data, dr_out_0<=~in_data, clear counters and err, go to DATA_WAIT.
- DATA_WAIT:
  - Settle counter increments each cycle completion holds and clears when it drops.
  - Illegal seen on any cycle sets internal err.
  - When completion has been seen for SETTLE consecutive cycles: res_data<=s1, drive spacer, go to NULL_WAIT.
  - Timeout: capture res_data<=s1, set err, drive spacer, go to NULL_WAIT.
- NULL_WAIT:
  - Same settle rule applied to null.
  - On settle: go to RESP with res_valid<=1 and res_err<=err.
  - Timeout: set err, go to RESP.
- RESP:
  - res_valid, res_data and res_err are held stable until res_ready.
  - res_valid&res_ready: res_valid<=0, go to IDLE. in_ready is 1 the cycle after the handshake; no back-to-back overlap.
- Timeout counter clears on entry to DATA_WAIT and to NULL_WAIT. Timeout fires on the edge where the count reaches TIMEOUT.
- Latency, zero-delay block, SETTLE=2, accept at edge 0:
  - Codeword on dr_out after edge 1.
  - Capture and spacer at edge 5.
  - res_valid high after edge 9.
- dr_out only changes at IDLE→DATA_WAIT and DATA_WAIT→NULL_WAIT. A codeword never directly follows a codeword without a spacer.
- Reset mid-operation: immediate spacer, outputs cleared. The dual-rail block is allowed to return to null unobserved.
- A result with res_err=1 is still delivered, and the bridge returns to IDLE normally.

Test Plan:
- Bench model: dual-rail block computes (a|b)&(c|d) with 0-cycle delay; in_data={d,c,b,a}.
  - in_data=4'b0101 accepted at edge 0 → res_valid after edge 9, res_data=1, res_err=0.
  - in_data=4'b0011 → res_data=0, res_err=0.
- Block delay 3 cycles on result and on null → res_valid after edge 15, correct data, err=0.
- Block never asserts completion → timeout after 15 cycles in DATA_WAIT. Spacer follows, then res_valid with res_err=1.
- Block drives out_1=out_0=1 for 4 cycles, then a valid codeword → res_data correct, res_err=1.
- res_ready held low 10 cycles in RESP → res_valid/res_data stable, in_ready=0 throughout, and in_valid is ignored.
- rst_n pulsed low while in DATA_WAIT → dr_out_1=dr_out_0=0 immediately, res_valid=0. After release, a fresh transaction completes with correct data.
